// File: rtl/mc_main_control.sv
// mc_main_control
// Main control FSM for a multicycle MIPS datapath. It steps one instruction
// through fetch, decode, execute, memory and writeback cycles, sharing a
// single ALU, register file, memory port and PC. It drives every datapath
// mux select and write enable, plus the 2-bit ALUOp that the downstream
// ALU-function decoder consumes. The memory port can stall the sequence by
// holding mem_ready low in FETCH, MEMRD or MEMWR.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   Op           opcode from the instruction register (valid from DECODE on)
//   mem_ready    memory port finished the current access this cycle
//   PCWrite      unconditional PC load
//   PCWriteCond  PC load qualified by ALU Zero in the datapath
//   IorD         memory address select: 0 = PC, 1 = ALUOut
//   MemRead      memory read request
//   MemWrite     memory write request
//   IRWrite      instruction register load
//   MemtoReg     register write data select: 1 = MDR
//   PCSource     PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
//   ALUOp        00 = add, 01 = subtract, 10 = decode funct
//   ALUSrcA      0 = PC, 1 = register A
//   ALUSrcB      00 = B, 01 = 4, 10 = sign-extended imm, 11 = imm << 2
//   RegWrite     register file write
//   RegDst       destination select: 1 = rd, 0 = rt
//   illegal_op   one-cycle pulse in DECODE on an unsupported opcode
//   state        current state encoding (debug)
module mc_main_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d     = S_FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    illegal_op  = 1'b0;

    case (state_q)
      S_FETCH: begin
        // PC+4 is computed alongside the fetch; IR and PC only commit
        // once memory has actually returned the instruction.
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        state_d = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is precomputed here into ALUOut.
        ALUSrcB = 2'b11;
        if ((Op == OP_LW) || (Op == OP_SW)) state_d = S_MEMADR;
        else if (Op == OP_RTYPE)            state_d = S_EXEC;
        else if (Op == OP_BEQ)              state_d = S_BRANCH;
        else if (Op == OP_J)                state_d = S_JUMP;
        else if (Op == OP_ADDI)             state_d = S_ADDIEX;
        else begin
          illegal_op = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        // Write request is held for the whole stall.
        MemWrite = 1'b1;
        IorD     = 1'b1;
        state_d  = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_RWB;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        state_d  = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset must abandon the instruction immediately, so no write or
    // memory request may escape during the reset cycle itself.
    if (!rst_n) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      illegal_op  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_main_control.sv
module tb_mc_main_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Op;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic       ALUSrcA, RegWrite, RegDst, illegal_op;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mc_main_control dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .RegDst(RegDst), .illegal_op(illegal_op), .state(state)
  );

  // Control word layout:
  // PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg
  // PCSource[1:0] ALUOp[1:0] ALUSrcA ALUSrcB[1:0] RegWrite RegDst illegal_op
  logic [16:0] ctrl;
  assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                 PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, illegal_op};

  localparam logic [16:0] C_F1   = 17'b1_0_0_1_0_1_0_00_00_0_01_0_0_0;
  localparam logic [16:0] C_F0   = 17'b0_0_0_1_0_0_0_00_00_0_01_0_0_0;
  localparam logic [16:0] C_RST  = 17'b0_0_0_0_0_0_0_00_00_0_01_0_0_0;
  localparam logic [16:0] C_DEC  = 17'b0_0_0_0_0_0_0_00_00_0_11_0_0_0;
  localparam logic [16:0] C_DILL = 17'b0_0_0_0_0_0_0_00_00_0_11_0_0_1;
  localparam logic [16:0] C_MADR = 17'b0_0_0_0_0_0_0_00_00_1_10_0_0_0;
  localparam logic [16:0] C_MRD  = 17'b0_0_1_1_0_0_0_00_00_0_00_0_0_0;
  localparam logic [16:0] C_MWB  = 17'b0_0_0_0_0_0_1_00_00_0_00_1_0_0;
  localparam logic [16:0] C_MWR  = 17'b0_0_1_0_1_0_0_00_00_0_00_0_0_0;
  localparam logic [16:0] C_MWRR = 17'b0_0_1_0_0_0_0_00_00_0_00_0_0_0;
  localparam logic [16:0] C_EX   = 17'b0_0_0_0_0_0_0_00_10_1_00_0_0_0;
  localparam logic [16:0] C_RWB  = 17'b0_0_0_0_0_0_0_00_00_0_00_1_1_0;
  localparam logic [16:0] C_BR   = 17'b0_1_0_0_0_0_0_01_01_1_00_0_0_0;
  localparam logic [16:0] C_J    = 17'b1_0_0_0_0_0_0_10_00_0_00_0_0_0;
  localparam logic [16:0] C_AWB  = 17'b0_0_0_0_0_0_0_00_00_0_00_1_0_0;

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; Op = 6'b100011;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (state !== 4'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d expected 0", state);
    end
    n_checks++;
    if (ctrl !== C_RST) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, C_RST);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_lw();
    logic [3:0]  st [6] = '{0, 1, 2, 3, 4, 0};
    logic        mr [6] = '{1, 1, 1, 1, 1, 0};
    logic [16:0] cw [6] = '{C_F1, C_DEC, C_MADR, C_MRD, C_MWB, C_F0};
    Op = 6'b100011;
    for (int i = 0; i < 6; i++) begin
      mem_ready = mr[i]; #1;
      n_checks++;
      if (state !== st[i]) begin
        n_fail++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state, st[i]);
      end
      n_checks++;
      if (ctrl !== cw[i]) begin
        n_fail++; $display("FAIL lw_ctrl[%0d]: got %b expected %b", i, ctrl, cw[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype();
    logic [3:0]  st [5] = '{0, 1, 6, 7, 0};
    logic        mr [5] = '{1, 1, 1, 1, 0};
    logic [16:0] cw [5] = '{C_F1, C_DEC, C_EX, C_RWB, C_F0};
    Op = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      mem_ready = mr[i]; #1;
      n_checks++;
      if (state !== st[i]) begin
        n_fail++; $display("FAIL rtype_state[%0d]: got %0d expected %0d", i, state, st[i]);
      end
      n_checks++;
      if (ctrl !== cw[i]) begin
        n_fail++; $display("FAIL rtype_ctrl[%0d]: got %b expected %b", i, ctrl, cw[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_stall();
    logic [3:0]  st [10] = '{0, 0, 1, 2, 3, 3, 3, 3, 4, 0};
    logic        mr [10] = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 0};
    logic [16:0] cw [10] = '{C_F0, C_F1, C_DEC, C_MADR, C_MRD, C_MRD, C_MRD, C_MRD,
                             C_MWB, C_F0};
    Op = 6'b100011;
    for (int i = 0; i < 10; i++) begin
      mem_ready = mr[i]; #1;
      n_checks++;
      if (state !== st[i]) begin
        n_fail++; $display("FAIL lw_stall_state[%0d]: got %0d expected %0d", i, state, st[i]);
      end
      n_checks++;
      if (ctrl !== cw[i]) begin
        n_fail++; $display("FAIL lw_stall_ctrl[%0d]: got %b expected %b", i, ctrl, cw[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq_j();
    logic [3:0]  st [8] = '{0, 1, 8, 0, 0, 1, 9, 0};
    logic        mr [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
    logic [16:0] cw [8] = '{C_F1, C_DEC, C_BR, C_F0, C_F1, C_DEC, C_J, C_F0};
    for (int i = 0; i < 8; i++) begin
      Op = (i < 4) ? 6'b000100 : 6'b000010;
      mem_ready = mr[i]; #1;
      n_checks++;
      if (state !== st[i]) begin
        n_fail++; $display("FAIL beq_j_state[%0d]: got %0d expected %0d", i, state, st[i]);
      end
      n_checks++;
      if (ctrl !== cw[i]) begin
        n_fail++; $display("FAIL beq_j_ctrl[%0d]: got %b expected %b", i, ctrl, cw[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_addi_sw();
    logic [3:0]  st [11] = '{0, 1, 10, 11, 0, 0, 1, 2, 5, 5, 0};
    logic        mr [11] = '{1, 1, 1, 1, 0, 1, 1, 1, 0, 1, 0};
    logic [16:0] cw [11] = '{C_F1, C_DEC, C_MADR, C_AWB, C_F0,
                             C_F1, C_DEC, C_MADR, C_MWR, C_MWR, C_F0};
    for (int i = 0; i < 11; i++) begin
      Op = (i < 5) ? 6'b001000 : 6'b101011;
      mem_ready = mr[i]; #1;
      n_checks++;
      if (state !== st[i]) begin
        n_fail++; $display("FAIL addi_sw_state[%0d]: got %0d expected %0d", i, state, st[i]);
      end
      n_checks++;
      if (ctrl !== cw[i]) begin
        n_fail++; $display("FAIL addi_sw_ctrl[%0d]: got %b expected %b", i, ctrl, cw[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [3:0]  st [4] = '{0, 1, 0, 0};
    logic        mr [4] = '{1, 1, 0, 0};
    logic [16:0] cw [4] = '{C_F1, C_DILL, C_F0, C_F0};
    Op = 6'b111111;
    for (int i = 0; i < 4; i++) begin
      mem_ready = mr[i]; #1;
      n_checks++;
      if (state !== st[i]) begin
        n_fail++; $display("FAIL illegal_state[%0d]: got %0d expected %0d", i, state, st[i]);
      end
      n_checks++;
      if (ctrl !== cw[i]) begin
        n_fail++; $display("FAIL illegal_ctrl[%0d]: got %b expected %b", i, ctrl, cw[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0]  st [5] = '{0, 1, 2, 5, 5};
    logic        mr [5] = '{1, 1, 1, 0, 0};
    Op = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      mem_ready = mr[i]; #1;
      n_checks++;
      if (state !== st[i]) begin
        n_fail++; $display("FAIL rstmid_state[%0d]: got %0d expected %0d", i, state, st[i]);
      end
      if (i < 4) begin
        @(posedge clk); #1;
      end
    end
    // Still stalled in MEMWR: assert reset before the edge.
    rst_n = 1'b0; #1;
    n_checks++;
    if (MemWrite !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_memwrite: got %b expected 0", MemWrite);
    end
    n_checks++;
    if (ctrl !== C_MWRR) begin
      n_fail++; $display("FAIL rstmid_ctrl: got %b expected %b", ctrl, C_MWRR);
    end
    @(posedge clk); #1;
    n_checks++;
    if (state !== 4'd0) begin
      n_fail++; $display("FAIL rstmid_after_edge: got %0d expected 0", state);
    end
    rst_n = 1'b1; mem_ready = 1'b1; Op = 6'b000000; #1;
    n_checks++;
    if (ctrl !== C_F1) begin
      n_fail++; $display("FAIL rstmid_refetch_ctrl: got %b expected %b", ctrl, C_F1);
    end
    @(posedge clk); #1;
    n_checks++;
    if (state !== 4'd1) begin
      n_fail++; $display("FAIL rstmid_refetch_state: got %0d expected 1", state);
    end
    n_checks++;
    if (ctrl !== C_DEC) begin
      n_fail++; $display("FAIL rstmid_decode_ctrl: got %b expected %b", ctrl, C_DEC);
    end
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; Op = 6'b000000;
    test_reset();
    test_lw();
    test_rtype();
    test_lw_stall();
    test_beq_j();
    test_addi_sw();
    test_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
- Multicycle MIPS main control FSM.
- Sequences the shared single ALU, register file, memory port and PC across fetch, decode, execute, memory and writeback cycles.
- Drives the 2-bit ALUOp consumed by the downstream ALU-function decoder, plus all datapath mux selects and write enables.
- Supports a memory ready handshake so the memory port may stall the sequence.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word opcode
- OP_SW, 6'b101011, store word opcode
- OP_BEQ, 6'b000100, branch-equal opcode
- OP_J, 6'b000010, jump opcode
- OP_ADDI, 6'b001000, add-immediate opcode

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- Op  in  6  opcode field from instruction register (valid from DECODE onward)
- mem_ready  in  1  memory port completed the current access this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load qualified by ALU Zero in the datapath
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  register write data select: 1=MDR
- PCSource  out  2  PC source: 00=ALU, 01=ALUOut, 10=jump target
- ALUOp  out  2  00=add, 01=subtract, 10=decode funct
- ALUSrcA  out  1  0=PC, 1=register A
- ALUSrcB  out  2  00=B, 01=const 4, 10=sign-extended imm, 11=imm<<2
- RegWrite  out  1  register file write
- RegDst  out  1  destination select: 1=rd, 0=rt
- illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode
- state  out  4  current state encoding (debug)

Behaviour:
- Single registered 4-bit state; all outputs are combinational decodes of state, plus mem_ready where noted.
- Every output not listed for a state is 0.
- Reset:
  - rst_n low at a rising edge forces state=FETCH (0).
  - While rst_n is low, all enables (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite) and illegal_op are forced 0 combinationally.
  - Reset mid-instruction abandons the instruction; no further writes occur.
- State encodings and outputs:
  - FETCH(0):
    - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
    - IRWrite=PCWrite=mem_ready.
    - Next state: DECODE if mem_ready, else FETCH.
  - DECODE(1):
    - ALUSrcA=0, ALUSrcB=11, ALUOp=00.
    - Next state by Op: LW/SW -> MEMADR; RTYPE -> EXEC; BEQ -> BRANCH; J -> JUMP; ADDI -> ADDIEX.
    - Any other Op: illegal_op=1 and next state is FETCH.
  - MEMADR(2):
    - ALUSrcA=1, ALUSrcB=10, ALUOp=00.
    - Next state: MEMRD if Op==LW, else MEMWR.
  - MEMRD(3):
    - MemRead=1, IorD=1.
    - Next state: MEMWB if mem_ready, else hold.
  - MEMWB(4): RegWrite=1, MemtoReg=1, RegDst=0. Next state: FETCH.
  - MEMWR(5):
    - MemWrite=1, IorD=1.
    - Next state: FETCH if mem_ready, else hold.
    - MemWrite stays asserted throughout the stall.
  - EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state: RWB.
  - RWB(7): RegWrite=1, RegDst=1, MemtoReg=0. Next state: FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next state: FETCH.
  - JUMP(9): PCWrite=1, PCSource=10. Next state: FETCH.
  - ADDIEX(10): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state: ADDIWB.
  - ADDIWB(11): RegWrite=1, RegDst=0, MemtoReg=0. Next state: FETCH.
  - Encodings 12-15 are unreachable. If entered, all outputs are 0 and next state is FETCH.
- Op is sampled every cycle in DECODE/MEMADR; it must stay stable from DECODE until return to FETCH (IR is held because IRWrite=0).
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- Latency with mem_ready held 1, counting FETCH through the last state:
  - lw = 5 cycles
  - sw = 4
  - R-type = 4
  - addi = 4
  - beq = 3
  - j = 3

Test Plan:
- Reset then lw (Op=100011), mem_ready=1:
  - state sequence 0,1,2,3,4,0.
  - IRWrite/PCWrite high only in cycle 0.
  - RegWrite=1, MemtoReg=1 in state 4.
- R-type (Op=0): sequence 0,1,6,7,0; ALUOp=10 in state 6; RegWrite=1, RegDst=1 in state 7.
- lw with mem_ready low for 3 cycles in MEMRD:
  - state 3 held 4 cycles with MemRead=1, IorD=1.
  - RegWrite never asserts until state 4.
  - FETCH stall with mem_ready=0 keeps IRWrite=PCWrite=0.
- beq (Op=000100) then j (Op=000010):
  - state 8 drives ALUOp=01, PCWriteCond=1, PCSource=01.
  - state 9 drives PCWrite=1, PCSource=10.
- Op=6'b111111 in DECODE: illegal_op=1 for exactly one cycle, next state 0, no write enable asserted.
- rst_n driven low during MEMWR stall (mem_ready=0):
  - MemWrite drops to 0 the same cycle.
  - state=0 after the edge.
  - resumes a normal fetch once rst_n is high.
